// File: rtl/adc_display_filter.sv
// ---------------------------------------------------------------------------
// adc_display_filter
//
// Samples a free-running 12-bit ADC reading (1 LSB = 1 mV) every SAMPLE_DIV
// clocks. The samples go into a 16-entry circular buffer. A running sum
// gives a 16-sample moving average. Every UPDATE_DIV samples the average is
// converted to four BCD digits with a sequential double-dabble engine, so the
// value can drive a seven-segment display.
//
// Parameters
//   SAMPLE_DIV : clk cycles per ADC capture (2 .. 2^20)
//   UPDATE_DIV : captured samples per display refresh (1 .. 2^16)
//
// Ports
//   clk       : system clock, everything on the rising edge
//   rst_n     : synchronous active-low reset
//   adc_value : current ADC reading in mV
//   avg       : registered 16-sample moving average in mV
//   bcd       : four BCD digits of the last converted average, thousands
//               in [15:12]
//   bcd_valid : one-cycle pulse when bcd is updated
//   busy      : high while a BCD conversion is in progress
// ---------------------------------------------------------------------------
module adc_display_filter #(
    parameter int SAMPLE_DIV = 50000,
    parameter int UPDATE_DIV = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] adc_value,
    output logic [11:0] avg,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic        busy
);

    localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int UW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [UW-1:0] UPDATE_LAST = UW'(UPDATE_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [SW-1:0] sampleCnt_q, sampleCnt_d;
    logic [UW-1:0] updCnt_q, updCnt_d;
    logic          sampleTick;
    logic          convReq_q, convReq_d;

    logic [11:0]   buffer_q [16];
    logic [3:0]    wrPtr_q, wrPtr_d;
    logic [15:0]   sum_q, sum_d;
    logic [11:0]   avg_q, avg_d;

    logic [1:0]    state_q, state_d;
    logic [11:0]   operand_q, operand_d;
    logic [15:0]   scratch_q, scratch_d;
    logic [15:0]   adjusted;
    logic [3:0]    bitCnt_q, bitCnt_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          bcdValid_q, bcdValid_d;
    logic          busy_q, busy_d;

    // Sample/update dividers and the moving-average datapath.
    // The evicted buffer entry is always part of sum_q, so the subtraction
    // cannot underflow, and 16 * 4095 fits in 16 bits.
    always_comb begin
        sampleTick  = (sampleCnt_q == SAMPLE_LAST);
        sampleCnt_d = sampleTick ? '0 : sampleCnt_q + SW'(1);
        updCnt_d    = updCnt_q;
        convReq_d   = 1'b0;
        wrPtr_d     = wrPtr_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        if (sampleTick) begin
            updCnt_d  = (updCnt_q == UPDATE_LAST) ? '0 : updCnt_q + UW'(1);
            convReq_d = (updCnt_q == UPDATE_LAST);
            wrPtr_d   = wrPtr_q + 4'd1;
            sum_d     = sum_q - {4'd0, buffer_q[wrPtr_q]} + {4'd0, adc_value};
            avg_d     = sum_d[15:4];
        end
    end

    // Double-dabble conversion FSM. convReq_q is a single-cycle pulse. A
    // request that arrives outside IDLE is therefore simply lost. bitCnt
    // counts down the 12 shift iterations.
    always_comb begin
        state_d    = state_q;
        operand_d  = operand_q;
        scratch_d  = scratch_q;
        bitCnt_d   = bitCnt_q;
        bcd_d      = bcd_q;
        bcdValid_d = 1'b0;
        busy_d     = busy_q;
        adjusted   = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5) begin
                adjusted[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (convReq_q) begin
                    state_d   = SHIFT;
                    operand_d = avg_q;
                    scratch_d = '0;
                    bitCnt_d  = 4'd12;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                {scratch_d, operand_d} = {adjusted, operand_q} << 1;
                bitCnt_d = bitCnt_q - 4'd1;
                if (bitCnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = scratch_q;
                bcdValid_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sampleCnt_q <= '0;
            updCnt_q    <= '0;
            convReq_q   <= 1'b0;
            wrPtr_q     <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            state_q     <= IDLE;
            operand_q   <= '0;
            scratch_q   <= '0;
            bitCnt_q    <= '0;
            bcd_q       <= '0;
            bcdValid_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buffer_q[i] <= '0;
            end
        end else begin
            sampleCnt_q <= sampleCnt_d;
            updCnt_q    <= updCnt_d;
            convReq_q   <= convReq_d;
            wrPtr_q     <= wrPtr_d;
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            state_q     <= state_d;
            operand_q   <= operand_d;
            scratch_q   <= scratch_d;
            bitCnt_q    <= bitCnt_d;
            bcd_q       <= bcd_d;
            bcdValid_q  <= bcdValid_d;
            busy_q      <= busy_d;
            if (sampleTick) begin
                buffer_q[wrPtr_q] <= adc_value;
            end
        end
    end

    assign avg       = avg_q;
    assign bcd       = bcd_q;
    assign bcd_valid = bcdValid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adc_display_filter.sv
// ---------------------------------------------------------------------------
// tb_adc_display_filter
//
// Directed bench for adc_display_filter. Instance A uses SAMPLE_DIV=4 and
// UPDATE_DIV=16. Instance B uses SAMPLE_DIV=8 and UPDATE_DIV=1, so every
// sample requests a conversion. Both instances share one ADC input and one
// clock. The instance that is not under test is held in reset.
//
// Stimulus is driven and outputs are sampled on the falling clock edge.
// Edge numbers in the comments count rising edges after reset release.
// ---------------------------------------------------------------------------
module tb_adc_display_filter;

    logic        clk = 1'b0;
    logic        rstA_n;
    logic        rstB_n;
    logic [11:0] adcVal;
    logic [11:0] avgA, avgB;
    logic [15:0] bcdA, bcdB;
    logic        validA, validB;
    logic        busyA, busyB;

    int testsRun    = 0;
    int testsFailed = 0;
    int pulses;

    logic [11:0] bndVals [5] = '{12'd0, 12'd9, 12'd10, 12'd999, 12'd4094};
    logic [15:0] bndExp  [5] = '{16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h4094};

    always #5 clk = ~clk;

    adc_display_filter #(.SAMPLE_DIV(4), .UPDATE_DIV(16)) dutA (
        .clk       (clk),
        .rst_n     (rstA_n),
        .adc_value (adcVal),
        .avg       (avgA),
        .bcd       (bcdA),
        .bcd_valid (validA),
        .busy      (busyA)
    );

    adc_display_filter #(.SAMPLE_DIV(8), .UPDATE_DIV(1)) dutB (
        .clk       (clk),
        .rst_n     (rstB_n),
        .adc_value (adcVal),
        .avg       (avgB),
        .bcd       (bcdB),
        .bcd_valid (validB),
        .busy      (busyB)
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [11:0] value, input int n);
        adcVal = value;
        cycles(n);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Resets both instances for two edges, then releases the one under test.
    task automatic resetDut(input bit releaseB);
        rstA_n = 1'b0;
        rstB_n = 1'b0;
        cycles(2);
        if (releaseB) rstB_n = 1'b1;
        else          rstA_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstA_n = 1'b0;
        rstB_n = 1'b0;
        adcVal = 12'd0;
        cycles(2);

        // Outputs while held in reset
        checkOutput("rstAvgA",   avgA,   0);
        checkOutput("rstBcdA",   bcdA,   0);
        checkOutput("rstValidA", validA, 0);
        checkOutput("rstBusyA",  busyA,  0);
        checkOutput("rstBcdB",   bcdB,   0);

        // Full scale: ticks at edges 4, 8, ..., 64. The conversion starts
        // at edge 65 and bcd_valid rises at edge 78.
        adcVal = 12'd4095;
        resetDut(0);
        cycles(3);
        checkOutput("firstTickEarly", avgA, 0);
        cycles(1);
        checkOutput("firstTick", avgA, 255);
        cycles(59);
        checkOutput("avgAfter15", avgA, 3839);
        cycles(1);
        checkOutput("avgAfter16", avgA, 4095);
        checkOutput("busyBeforeStart", busyA, 0);
        cycles(1);
        checkOutput("busyStart", busyA, 1);
        cycles(12);
        checkOutput("busyLast", busyA, 1);
        checkOutput("validEarly", validA, 0);
        cycles(1);
        checkOutput("fullValid", validA, 1);
        checkOutput("fullBcd", bcdA, 32'h4095);
        checkOutput("fullBusyDrop", busyA, 0);
        cycles(1);
        checkOutput("fullValidPulse", validA, 0);
        checkOutput("fullBcdHold", bcdA, 32'h4095);

        // Eviction and pointer wrap: 16 x 1000, then 2600 on the 17th tick.
        // A different value between ticks must not reach the average.
        adcVal = 12'd1000;
        resetDut(0);
        cycles(64);
        checkOutput("evictAvg1000", avgA, 1000);
        applyStimulus(12'd3000, 2);
        checkOutput("betweenTicks", avgA, 1000);
        applyStimulus(12'd2600, 2);
        checkOutput("evictAvg1100", avgA, 1100);
        cycles(10);
        checkOutput("bcd1000Valid", validA, 1);
        checkOutput("bcd1000", bcdA, 32'h1000);

        // Boundary values, each held for 16 ticks
        for (int i = 0; i < 5; i++) begin
            adcVal = bndVals[i];
            resetDut(0);
            cycles(78);
            checkOutput($sformatf("bnd%0dValid", bndVals[i]), validA, 1);
            checkOutput($sformatf("bnd%0dBcd", bndVals[i]), bcdA, {16'd0, bndExp[i]});
        end

        // Reset for one cycle, five cycles into SHIFT (SHIFT begins at edge 65)
        adcVal = 12'd4095;
        resetDut(0);
        cycles(69);
        checkOutput("midShiftBusy", busyA, 1);
        rstA_n = 1'b0;
        cycles(1);
        checkOutput("abortBusy",  busyA,  0);
        checkOutput("abortBcd",   bcdA,   0);
        checkOutput("abortValid", validA, 0);
        checkOutput("abortAvg",   avgA,   0);
        rstA_n = 1'b1;
        adcVal = 12'd800;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            if (validA) pulses++;
        end
        checkOutput("abortBufEmpty", avgA, 50);
        for (int i = 0; i < 73; i++) begin
            cycles(1);
            if (validA) pulses++;
        end
        checkOutput("abortNoValid", pulses, 0);
        cycles(1);
        checkOutput("abortNextValid", validA, 1);
        checkOutput("abortNextBcd", bcdA, 32'h0800);

        // Instance B: one tick of 160, then 0. Requests arrive at edges
        // 8, 16, 24, ... The request at 16 lands mid-conversion and is
        // dropped, so bcd_valid pulses occur at edges 22, 38 and 54.
        adcVal = 12'd160;
        resetDut(1);
        pulses = 0;
        for (int i = 1; i <= 64; i++) begin
            cycles(1);
            if (validB) pulses++;
            if (i == 8) begin
                checkOutput("bAvg10", avgB, 10);
                adcVal = 12'd0;
            end
            if (i == 9)  checkOutput("bBusyStart", busyB, 1);
            if (i == 16) checkOutput("bAvgHold", avgB, 10);
            if (i == 17) checkOutput("bBusyDuringDrop", busyB, 1);
            if (i == 22) begin
                checkOutput("bValid1", validB, 1);
                checkOutput("bBcd1", bcdB, 32'h0010);
            end
            if (i == 30) checkOutput("bDroppedNoValid", validB, 0);
            if (i == 38) begin
                checkOutput("bValid2", validB, 1);
                checkOutput("bBcd2", bcdB, 32'h0010);
            end
        end
        checkOutput("bPulseCount", pulses, 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/adc_display_filter.md
ADC_DISPLAY_FILTER -- requirements
Module: adc_display_filter

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 50000: clk cycles per ADC sample capture (1 kHz at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter UPDATE_DIV, default 250: captured samples per display refresh (4 Hz); legal range 1..2^16.
REQ-003 SHALL have port clk  input  1  system clock (CLOCK_50); all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port adc_value  input  12  free-running unipolar ADC_Read result, 1 LSB = 1 mV.
REQ-006 SHALL have port avg  output  12  registered 16-sample moving average in mV.
REQ-007 SHALL have port bcd  output  16  four BCD digits of the last converted avg, thousands in [15:12]; drives full_sevenseg value.
REQ-008 SHALL have port bcd_valid  output  1  one-cycle pulse when bcd is updated.
REQ-009 SHALL have port busy  output  1  high while a BCD conversion is in progress.

Function
REQ-010 SHALL run a sample divider counting 0..SAMPLE_DIV-1 and wrapping; sample_tick is asserted in the cycle the count equals SAMPLE_DIV-1.
REQ-011 On sample_tick, the block SHALL write adc_value into a 16-entry circular buffer at wr_ptr, and wr_ptr SHALL increment mod 16 (15 wraps to 0).
REQ-012 On the same edge, sum SHALL be updated to sum - buffer[wr_ptr] + adc_value; sum SHALL be 16 bits unsigned (maximum 65520, no overflow).
REQ-013 avg SHALL equal sum[15:4], registered; it SHALL reflect a sample one cycle after that sample's sample_tick.
REQ-014 Before 16 samples have been captured, empty buffer entries SHALL count as 0, so avg ramps up; there is no pre-fill.
REQ-015 An update counter SHALL count sample_ticks 0..UPDATE_DIV-1; on the tick where it equals UPDATE_DIV-1, the counter SHALL wrap and conv_req SHALL be set.
REQ-016 The conversion FSM SHALL have states IDLE, SHIFT, DONE.
REQ-017 IDLE -> SHIFT: the FSM SHALL make this transition the cycle after conv_req if IDLE, latching avg (which already includes the triggering sample), clearing a 16-bit scratch register, loading bit count 12, and asserting busy.
REQ-018 In SHIFT, the FSM SHALL perform one double-dabble iteration per cycle: add 3 to each scratch nibble >= 5, then shift {scratch, operand} left by 1; it SHALL take exactly 12 cycles, then go to DONE.
REQ-019 In DONE (one cycle), bcd SHALL be loaded from scratch, bcd_valid SHALL be pulsed for that cycle, busy SHALL drop, and the FSM SHALL return to IDLE.
REQ-020 Latency from the triggering sample_tick edge to bcd_valid high SHALL be 14 cycles; busy SHALL be high 13 cycles (SHIFT and DONE... busy low in DONE: SHIFT only, 12 cycles plus the start cycle).
REQ-021 A conv_req arriving while not IDLE SHALL be dropped (no queuing); bcd SHALL keep its prior value until the next accepted request.
REQ-022 bcd SHALL be held stable between bcd_valid pulses; adc_value changes between sample_ticks SHALL have no effect.
REQ-023 Every bcd nibble SHALL be 0..9; input 4095 SHALL yield 0x4095.

Reset
REQ-024 While rst_n = 0 at a clk edge, all 16 buffer entries, sum, avg, wr_ptr, both divider counters, bcd, bcd_valid, busy, and conv_req SHALL clear to 0, and the FSM SHALL go to IDLE.
REQ-025 Reset asserted mid-conversion SHALL abort it; bcd SHALL read 0x0000 and no bcd_valid pulse SHALL follow.
REQ-026 The first sample_tick after reset release SHALL occur SAMPLE_DIV cycles after the first clk edge with rst_n = 1.

Verification (SAMPLE_DIV=4, UPDATE_DIV=16 unless stated)
REQ-027 adc_value held at 4095 for 16 ticks -> avg=4095 after the 16th tick; bcd=0x4095 with bcd_valid 14 cycles after that tick.
REQ-028 After reset, one tick at 160 then 0 (UPDATE_DIV=1) -> avg=10; bcd=0x0010 after 1st conversion, 0x0010 after 2nd.
REQ-029 16 ticks of 1000 then a 17th of 2600 -> sum 16000->17600; avg 1000->1100, confirming oldest-entry eviction and wr_ptr wrap 15->0.
REQ-030 UPDATE_DIV=1, SAMPLE_DIV=8: conv_req every 8 cycles overlapping a 13-cycle conversion -> every other request dropped; one bcd_valid per 16 cycles, no corruption.
REQ-031 rst_n low for one cycle, 5 cycles into SHIFT -> busy=0, bcd=0x0000, no bcd_valid, buffer empty; next full update gives the correct value.
REQ-032 Boundary values 0, 9, 10, 999, 1000, 4094 held 16 ticks -> bcd 0x0000, 0x0009, 0x0010, 0x0999, 0x1000, 0x4094.
